fifo_wr_arbiter: RTL and testbench

- Round-robin write-side arbiter sharing one sync_fifo write port among NUM_REQ producers.
- Each producer uses a req/ack handshake. The arbiter drives the FIFO's wr_en/wdata.
- Keeps a local credit count of free FIFO slots, so it never overflows the FIFO even though the FIFO's full flag is registered.
- Provides a drain sequence (stop granting, wait for the FIFO to empty) for mode changes upstream.

---
 rtl/fifo_wr_arbiter_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_if.sv | 24 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 136 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the fifo_wr_arbiter slice.
// Optional statistics ports are enabled with `define FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_FIFO_SIZE = 16;
  localparam int unsigned DEF_NUM_REQ   = 4;

  // Credit counter must represent 0..fifo_size inclusive.
  function automatic int unsigned cred_width(input int unsigned fifo_size);
    return $clog2(fifo_size + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer req/ack bundle plus the FIFO write/credit-return signals.
// master = arbiter side, slave = producers/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       ack;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wdata;
  logic                     fifo_rd_en;
  logic                     fifo_empty;

  modport master (
    input  req, req_data, fifo_rd_en, fifo_empty,
    output ack, fifo_wr_en, fifo_wdata
  );

  modport slave (
    output req, req_data, fifo_rd_en, fifo_empty,
    input  ack, fifo_wr_en, fifo_wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set bit of elig_i at or
// after ptr_i, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [PTR_W-1:0]   idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned j;
      j = (32'(ptr_i) + k) % NUM_REQ;
      if (!valid_o && elig_i[j]) begin
        valid_o = 1'b1;
        idx_o   = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with local credit tracking and drain FSM.
// `define FIFO_ARB_STATS_EN adds grant_cnt/stall_cnt statistics outputs.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned FIFO_SIZE = DEF_FIFO_SIZE,
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned CRED_W    = cred_width(FIFO_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_wr_arbiter_if.master    bus,
  input  logic                 drain_req,
  output logic                 drain_done,
  output logic [CRED_W-1:0]    credits
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] grant_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_SIZE);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d, elig;
  logic               wr_en_q, wr_en_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, win;
  logic               win_vld;
  logic [CRED_W-1:0]  cred_q, cred_d;
  logic               done_q;
  logic               grant, cred_inc;

  // A producer whose ack is still visible has not yet replaced its word.
  assign elig     = bus.req & ~ack_q;
  assign grant    = (state_q == RUN) && !drain_req && win_vld && (cred_q != '0);
  assign cred_inc = bus.fifo_rd_en & ~bus.fifo_empty;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .valid_o (win_vld),
    .idx_o   (win)
  );

  always_comb begin
    ack_d   = '0;
    wr_en_d = grant;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    if (grant) begin
      ack_d[win] = 1'b1;
      wdata_d    = bus.req_data[int'(win)*WIDTH +: WIDTH];
      ptr_d      = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  always_comb begin
    cred_d = cred_q;
    if (cred_inc && !grant && cred_q != CRED_MAX) begin
      cred_d = cred_q + 1'b1;
    end else if (grant && !cred_inc && cred_q != '0) begin
      cred_d = cred_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN: begin
        if (!drain_req)                            state_d = RUN;
        else if (cred_q == CRED_MAX && !wr_en_q)   state_d = DONE;
      end
      DONE:    if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ack_q   <= '0;
      wr_en_q <= 1'b0;
      wdata_q <= '0;
      ptr_q   <= '0;
      cred_q  <= CRED_MAX;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      wr_en_q <= wr_en_d;
      wdata_q <= wdata_d;
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.ack        = ack_q;
  assign bus.fifo_wr_en = wr_en_q;
  assign bus.fifo_wdata = wdata_q;
  assign drain_done     = done_q;
  assign credits        = cred_q;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] gcnt_q [NUM_REQ];
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (ack_d[i] && gcnt_q[i] != '1) gcnt_q[i] <= gcnt_q[i] + 16'd1;
      end
      if (|elig && cred_q == '0 && stall_q != '1) stall_q <= stall_q + 16'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = gcnt_q[i];
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer queues, FIFO occupancy
// model and expected-write queue checked every cycle at negedge.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned FS = 16;
  localparam int unsigned NR = 4;
  localparam int unsigned CW = cred_width(FS);

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          drain_req = 1'b0;
  logic          drain_done;
  logic [CW-1:0] credits;
`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0] grant_cnt;
  logic [15:0]      stall_cnt;
`endif

  fifo_wr_arbiter_if #(.WIDTH(W), .NUM_REQ(NR)) bus ();

  fifo_wr_arbiter #(
    .WIDTH     (W),
    .FIFO_SIZE (FS),
    .NUM_REQ   (NR),
    .CRED_W    (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .credits    (credits)
`ifdef FIFO_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  exp_t       sb[$];
  logic [7:0] prod_q[NR][$];
  int         occ = 0;
  int         cred_exp = FS;
  int         wr_cnt = 0;
  int         stepno = 0;
  int         acks_seen[NR];
  logic [NR-1:0] prev_ack = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic bit prod_busy();
    for (int i = 0; i < NR; i++) if (prod_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_prod();
    for (int i = 0; i < NR; i++) begin
      bus.req[i] = (prod_q[i].size() != 0);
      bus.req_data[i*W +: W] = (prod_q[i].size() != 0) ? prod_q[i][0] : 8'h00;
    end
  endtask

  // One clock: model FIFO/credits across the edge, then score DUT outputs.
  task automatic step();
    logic wr_pend, rd_now, rst_now;
    int   idx;
    exp_t e;
    wr_pend = bus.fifo_wr_en;
    rd_now  = bus.fifo_rd_en & ~bus.fifo_empty;
    rst_now = rst;
    @(negedge clk);
    stepno++;
    if (rst_now) begin
      occ = 0;
      cred_exp = FS;
      sb.delete();
      prev_ack = '0;
      for (int i = 0; i < NR; i++) acks_seen[i] = 0;
    end else begin
      occ += int'(wr_pend) - int'(rd_now);
      if (wr_pend) check("no_overflow", 64'(occ <= FS), 1);
      cred_exp += int'(rd_now);
      if (bus.fifo_wr_en) cred_exp--;
    end
    if (bus.fifo_wr_en) begin
      check("ack_onehot", 64'($onehot(bus.ack)), 1);
      idx = 0;
      for (int i = 0; i < NR; i++) if (bus.ack[i]) idx = i;
      acks_seen[idx]++;
      wr_cnt++;
      if (sb.size() == 0) check("unexpected_write", 1, 0);
      else begin
        e = sb.pop_front();
        check("ack_idx", idx, e.idx);
        check("wdata", bus.fifo_wdata, e.data);
      end
    end else begin
      check("ack_idle", bus.ack, 0);
    end
    if (bus.ack != '0) check("no_back_to_back", bus.ack & prev_ack, 0);
    prev_ack = bus.ack;
    check("credits", credits, cred_exp);
    for (int i = 0; i < NR; i++)
      if (bus.ack[i] && prod_q[i].size() != 0) void'(prod_q[i].pop_front());
    drive_prod();
    bus.fifo_empty = (occ == 0);
  endtask

  // Words go to producers in round-robin order, so that is the write order.
  task automatic queue_rr(input int total, input logic [7:0] base);
    logic [7:0] d;
    for (int n = 0; n < total; n++) begin
      d = base + 8'(16 * (n / NR) + (n % NR));
      prod_q[n % NR].push_back(d);
      sb.push_back('{n % NR, d});
    end
    drive_prod();
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((sb.size() != 0 || prod_busy() || bus.fifo_wr_en) && n < max) begin
      step();
      n++;
    end
    check("wait_idle_timeout", 64'(sb.size() != 0 || prod_busy()), 0);
  endtask

  task automatic reset_dut();
    for (int i = 0; i < NR; i++) prod_q[i].delete();
    drive_prod();
    bus.fifo_rd_en = 1'b0;
    drain_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wc, c16, dn;
    bus.req = '0;
    bus.req_data = '0;
    bus.fifo_rd_en = 1'b0;
    bus.fifo_empty = 1'b1;
    for (int i = 0; i < NR; i++) acks_seen[i] = 0;

    step();
    rst = 1'b0;
    check("rst_ack", bus.ack, 0);
    check("rst_wr_en", bus.fifo_wr_en, 0);
    check("rst_wdata", bus.fifo_wdata, 0);
    check("rst_drain_done", drain_done, 0);
    check("rst_credits", credits, FS);

    // All four request at once: 0,1,2,3 in order
    wc = wr_cnt;
    queue_rr(4, 8'hA0);
    for (int s = 0; s < 6; s++) step();
    check("t1_writes", wr_cnt - wc, 4);
    check("t1_credits", credits, 12);

    // Single producer, three words: acks never on consecutive cycles
    wc = wr_cnt;
    for (int k = 0; k < 3; k++) begin
      prod_q[0].push_back(8'h50 + 8'(k));
      sb.push_back('{0, 8'h50 + 8'(k)});
    end
    drive_prod();
    wait_idle(20);
    check("t2_writes", wr_cnt - wc, 3);

    // Fill to zero credits, then one read frees exactly one slot
    reset_dut();
    wc = wr_cnt;
    queue_rr(16, 8'h00);
    for (int i = 0; i < NR; i++) prod_q[i].push_back(8'h40 + 8'(i));
    drive_prod();
    for (int s = 0; s < 24; s++) step();
    check("t3_writes", wr_cnt - wc, 16);
    check("t3_credits", credits, 0);
    check("t3_occ", occ, 16);
`ifdef FIFO_ARB_STATS_EN
    check("t3_stall_nonzero", 64'(stall_cnt != 0), 1);
`endif
    sb.push_back('{0, 8'h40});
    bus.fifo_rd_en = 1'b1;
    step();
    bus.fifo_rd_en = 1'b0;
    wc = wr_cnt;
    step();
    step();
    check("t3_refill", wr_cnt - wc, 1);
    for (int s = 0; s < 3; s++) step();
    check("t3_refill_hold", wr_cnt - wc, 1);

    // Read and grant on the same edge at credits=5
    reset_dut();
    queue_rr(11, 8'h20);
    wait_idle(40);
    check("t4_pre_credits", credits, 5);
    prod_q[1].push_back(8'hC1);
    sb.push_back('{1, 8'hC1});
    drive_prod();
    bus.fifo_rd_en = 1'b1;
    step();
    bus.fifo_rd_en = 1'b0;
    check("t4_wr_en", bus.fifo_wr_en, 1);
    check("t4_credits", credits, 5);

    // Drain: no grants, drain_done one cycle after credits return to full
    reset_dut();
    queue_rr(6, 8'h60);
    wait_idle(30);
    check("t5_pre_credits", credits, 10);
    drain_req = 1'b1;
    prod_q[2].push_back(8'h77);
    drive_prod();
    for (int s = 0; s < 4; s++) begin
      step();
      check("t5_no_ack", bus.ack, 0);
    end
    check("t5_not_done", drain_done, 0);
    c16 = -1;
    dn = -1;
    for (int s = 0; s < 16; s++) begin
      bus.fifo_rd_en = (s < 6);
      step();
      if (credits == CW'(FS) && c16 < 0) c16 = stepno;
      if (drain_done && dn < 0) dn = stepno;
    end
    bus.fifo_rd_en = 1'b0;
    check("t5_done_latency", 64'(dn - c16), 1);
    check("t5_done_level", drain_done, 1);
    drain_req = 1'b0;
    sb.push_back('{2, 8'h77});
    wc = wr_cnt;
    step();
    check("t5_exit_done", drain_done, 0);
    wait_idle(10);
    check("t5_resume", wr_cnt - wc, 1);

    // Reset mid-burst at credits=9; pointer restarts at 0
    reset_dut();
    queue_rr(16, 8'h80);
    for (int s = 0; s < 20 && credits != CW'(9); s++) step();
    check("t6_reach9", credits, 9);
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NR; i++) check("t6_grant_cnt", grant_cnt[i*16 +: 16], acks_seen[i]);
`endif
    for (int i = 0; i < NR; i++) prod_q[i].delete();
    drive_prod();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_credits", credits, FS);
    check("t6_ack", bus.ack, 0);
    check("t6_wr_en", bus.fifo_wr_en, 0);
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NR; i++) check("t6_grant_cnt_clr", grant_cnt[i*16 +: 16], 0);
    check("t6_stall_clr", stall_cnt, 0);
`endif
    prod_q[1].push_back(8'h91);
    prod_q[3].push_back(8'h93);
    sb.push_back('{1, 8'h91});
    sb.push_back('{3, 8'h93});
    drive_prod();
    wait_idle(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
